// File: rtl/clip_pkg.sv
// Shared types and clip tables for the clip sequencer.
// Clip ids 0..15 are spoken digits, 16 is RED, 17 is GREEN.
package clip_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_ROM,
    PUSH,
    DONE
  } state_t;

  typedef logic [4:0] clip_id_t;

  localparam clip_id_t CLIP_RED   = 5'd16;
  localparam clip_id_t CLIP_GREEN = 5'd17;

  localparam int TAB_W     = 17;
  localparam int NUM_CLIPS = 18;

  localparam logic [TAB_W-1:0] CLIP_START [NUM_CLIPS] = '{
    17'h01000, 17'h01100, 17'h01200, 17'h01300,
    17'h01400, 17'h01500, 17'h01600, 17'h01700,
    17'h01800, 17'h01900, 17'h01a00, 17'h01b00,
    17'h01c00, 17'h01d00, 17'h01e00, 17'h01f00,
    17'h02000, 17'h03000
  };

  // Every length is at least one sample.
  localparam logic [TAB_W-1:0] CLIP_LEN [NUM_CLIPS] = '{
    17'd3, 17'd4, 17'd5, 17'd6,
    17'd3, 17'd4, 17'd5, 17'd6,
    17'd3, 17'd4, 17'd5, 17'd6,
    17'd3, 17'd4, 17'd5, 17'd6,
    17'd8, 17'd7
  };

  function automatic logic [TAB_W-1:0] clip_start(
    input clip_id_t id
  );
    if (id > CLIP_GREEN) return CLIP_START[0];
    return CLIP_START[id];
  endfunction

  function automatic logic [TAB_W-1:0] clip_len(
    input clip_id_t id
  );
    if (id > CLIP_GREEN) return CLIP_LEN[0];
    return CLIP_LEN[id];
  endfunction

endpackage

// File: rtl/clip_sequencer_rr_arbiter4.sv
// Four-way round-robin arbiter: search starts at ptr and
// wraps, first pending requester wins.
module rr_arbiter4 (
  input  logic [3:0] pending,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] gidx,
  output logic       any
);

  always_comb begin
    gnt  = '0;
    gidx = '0;
    any  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!any && pending[ptr + 2'(k)]) begin
        any                 = 1'b1;
        gidx                = ptr + 2'(k);
        gnt[ptr + 2'(k)]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clip_sequencer.sv
// Plays ROM clips to the CODEC for four requesters,
// one clip at a time, arbitrated round-robin.
module clip_sequencer
  import clip_pkg::*;
#(
  parameter int SAMPLE_W = 24,
  parameter int ADDR_W   = 17
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [3:0]          req,
  input  logic [3:0]          redCount,
  input  logic [3:0]          greenCount,
  input  logic                write_ready,
  output logic                write,
  output logic [SAMPLE_W-1:0] CODEC_write,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [SAMPLE_W-1:0] rom_data,
  output logic [3:0]          grant,
  output logic                busy,
  output logic                sampleDone
);

  state_t              state;
  state_t              state_n;
  logic [3:0]          pending;
  logic [3:0]          gnt;
  logic [1:0]          ptr;
  logic [1:0]          gidx;
  logic                any;
  clip_id_t            clip;
  clip_id_t            sel;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W-1:0]   last;
  logic [SAMPLE_W-1:0] sample;
  logic                take;
  logic                consume;

  rr_arbiter4 u_arb (
    .pending (pending),
    .ptr     (ptr),
    .gnt     (gnt),
    .gidx    (gidx),
    .any     (any)
  );

  always_comb begin
    sel = CLIP_RED;
    unique case (1'b1)
      gnt[0]:  sel = {1'b0, redCount};
      gnt[1]:  sel = {1'b0, greenCount};
      gnt[2]:  sel = CLIP_RED;
      gnt[3]:  sel = CLIP_GREEN;
      default: sel = CLIP_RED;
    endcase
  end

  assign last = ADDR_W'(clip_len(clip)) - 1'b1;

  always_comb begin
    state_n = state;
    take    = 1'b0;
    consume = 1'b0;
    unique case (state)
      IDLE: begin
        if (any) begin
          take    = 1'b1;
          state_n = FETCH;
        end
      end
      FETCH:    state_n = WAIT_ROM;
      WAIT_ROM: state_n = PUSH;
      PUSH: begin
        if (write_ready) begin
          consume = 1'b1;
          state_n = (idx == last) ? DONE : FETCH;
        end
      end
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pending  <= '0;
      ptr      <= '0;
      grant    <= '0;
      clip     <= '0;
      idx      <= '0;
      rom_addr <= '0;
      sample   <= '0;
    end else begin
      // A request for the index being granted survives the clear.
      pending <= (pending & ~(take ? gnt : 4'b0)) | req;
      if (take) begin
        ptr      <= gidx + 2'd1;
        grant    <= gnt;
        clip     <= sel;
        idx      <= '0;
        rom_addr <= ADDR_W'(clip_start(sel));
      end
      if (state == WAIT_ROM) sample <= rom_data;
      if (consume && state_n == FETCH) begin
        idx      <= idx + 1'b1;
        rom_addr <= rom_addr + 1'b1;
      end
      if (state == DONE) grant <= '0;
    end
  end

  assign busy        = (state != IDLE);
  assign write       = write_ready & ~reset;
  assign CODEC_write = (state == PUSH) ? sample : '0;
  assign sampleDone  = (state == DONE) & ~reset;

endmodule

// File: tb/tb_clip_sequencer.sv
// Scoreboard bench for clip_sequencer: a request-level model
// predicts every clip sample and end pulse in order.
module tb_clip_sequencer;

  localparam int SW = 24;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req;
  logic [3:0]    redCount;
  logic [3:0]    greenCount;
  logic          write_ready;
  logic          write;
  logic [SW-1:0] CODEC_write;
  logic [AW-1:0] rom_addr;
  logic [SW-1:0] rom_data = '0;
  logic [3:0]    grant;
  logic          busy;
  logic          sampleDone;

  always #5 clk = ~clk;

  clip_sequencer #(.SAMPLE_W(SW), .ADDR_W(AW)) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .req         (req),
    .redCount    (redCount),
    .greenCount  (greenCount),
    .write_ready (write_ready),
    .write       (write),
    .CODEC_write (CODEC_write),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .grant       (grant),
    .busy        (busy),
    .sampleDone  (sampleDone)
  );

  // ROM returns its own address one cycle later
  always @(posedge clk) rom_data <= SW'(rom_addr);

  typedef struct {
    bit          done;
    bit [3:0]    g;
    bit [SW-1:0] d;
  } exp_t;

  exp_t q[$];
  exp_t e;
  bit [3:0] m_pend;
  int  m_ptr;
  bit  m_active;
  int  m_popped;
  int  checks;
  int  passes;
  bit  bp_mode;

  function automatic void check(input string name,
                                input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endfunction

  function automatic int m_start(input int id);
    if (id == 16) return 'h2000;
    if (id == 17) return 'h3000;
    return 'h1000 + 'h100 * id;
  endfunction

  function automatic int m_len(input int id);
    if (id == 16) return 8;
    if (id == 17) return 7;
    return 3 + id % 4;
  endfunction

  function automatic void model_serve();
    int  who;
    int  id;
    exp_t x;
    if (m_active || m_pend == 0) return;
    who = -1;
    for (int k = 0; k < 4; k++)
      if (who < 0 && m_pend[(m_ptr + k) % 4]) who = (m_ptr + k) % 4;
    m_pend[who] = 1'b0;
    m_ptr = (who + 1) % 4;
    m_active = 1'b1;
    case (who)
      0: id = int'(redCount);
      1: id = int'(greenCount);
      2: id = 16;
      default: id = 17;
    endcase
    for (int n = 0; n < m_len(id); n++) begin
      x.done = 1'b0;
      x.g = 4'(1 << who);
      x.d = SW'(m_start(id) + n);
      q.push_back(x);
    end
    x.done = 1'b1;
    x.g = 4'(1 << who);
    x.d = '0;
    q.push_back(x);
  endfunction

  function automatic void model_req(input bit [3:0] v);
    m_pend |= v;
    model_serve();
  endfunction

  function automatic void model_reset();
    q.delete();
    m_pend = '0;
    m_ptr = 0;
    m_active = 1'b0;
  endfunction

  // Monitor: pops an expectation for every clip sample and end pulse
  always @(negedge clk) begin
    check("write_gate", write, write_ready && !reset);
    if (!reset && write && CODEC_write != 0) begin
      if (q.size() == 0) begin
        check("unexpected_sample", CODEC_write, 0);
      end else begin
        e = q.pop_front();
        m_popped++;
        check("sample_data", CODEC_write, e.done ? 0 : e.d);
        check("sample_grant", grant, e.g);
      end
    end
    if (sampleDone) begin
      if (q.size() == 0) begin
        check("unexpected_done", sampleDone, 0);
      end else begin
        e = q.pop_front();
        if (!e.done) check("early_done", sampleDone, 0);
        check("done_grant", grant, e.g);
        if (e.done) begin
          m_active = 1'b0;
          model_serve();
        end
      end
    end
  end

  initial begin
    write_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      write_ready = bp_mode ? ($urandom_range(0, 3) == 0) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse(input logic [3:0] v);
    @(posedge clk);
    #1;
    req = v;
    model_req(v);
    @(posedge clk);
    #1;
    req = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    req = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_done", sampleDone, 0);
    check("rst_codec", CODEC_write, 0);
    check("rst_addr", rom_addr, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((q.size() != 0 || m_active || m_pend != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drain"}, q.size(), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({name, "_idle_grant"}, grant, 0);
    check({name, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int n;
    int base;
    logic [3:0] v;
    checks = 0;
    passes = 0;
    m_popped = 0;
    bp_mode = 1'b0;
    reset = 1'b1;
    req = '0;
    redCount = '0;
    greenCount = '0;
    model_reset();
    do_reset();

    // single RED clip
    pulse(4'b0100);
    wait_drain(500, "single");

    // all four at once from reset: order 0,1,2,3
    do_reset();
    redCount = 4'd2;
    greenCount = 4'd9;
    pulse(4'b1111);
    wait_drain(1000, "arb");

    // tally frozen at grant
    redCount = 4'd7;
    pulse(4'b0001);
    repeat (4) @(posedge clk);
    #1;
    redCount = 4'd3;
    wait_drain(500, "freeze");

    // backpressure
    bp_mode = 1'b1;
    pulse(4'b0100);
    pulse(4'b1000);
    wait_drain(3000, "bp");
    bp_mode = 1'b0;

    // re-request while granted
    greenCount = 4'd5;
    pulse(4'b0010);
    n = 0;
    while (grant != 4'b0010 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("regrant_wait", grant, 4'b0010);
    pulse(4'b0010);
    pulse(4'b0010);
    wait_drain(500, "rereq");

    // reset mid-clip, after two samples consumed
    base = m_popped;
    pulse(4'b1000);
    n = 0;
    while (m_popped < base + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("midclip_wait", m_popped - base, 2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_grant", grant, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", sampleDone, 0);
    repeat (4) @(negedge clk);
    check("midrst_pending", busy, 0);
    pulse(4'b1000);
    wait_drain(500, "fresh");

    // randomized rounds
    for (int r = 0; r < 6; r++) begin
      redCount = 4'($urandom_range(0, 15));
      greenCount = 4'($urandom_range(0, 15));
      bp_mode = ($urandom_range(0, 1) == 1);
      for (int c = 0; c < 30; c++) begin
        @(posedge clk);
        #1;
        for (int b = 0; b < 4; b++) v[b] = ($urandom_range(0, 5) == 0);
        req = v;
        model_req(v);
      end
      @(posedge clk);
      #1;
      req = '0;
      wait_drain(6000, "rand");
    end
    bp_mode = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/clip_sequencer.md
CLIP_SEQUENCER -- requirements
Module: clip_sequencer

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 24, CODEC sample width.
REQ-002 SHALL have parameter ADDR_W, default 17, clip ROM address width.
REQ-003 SHALL have port CLOCK_50  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high.
REQ-005 SHALL have port req  in  4  one-cycle request pulses: [0] redCount, [1] greenCount, [2] red, [3] green.
REQ-006 SHALL have port redCount  in  4  red tally, sampled at grant.
REQ-007 SHALL have port greenCount  in  4  green tally, sampled at grant.
REQ-008 SHALL have port write_ready  in  1  CODEC can accept one stereo sample.
REQ-009 SHALL have port write  out  1  sample push to CODEC.
REQ-010 SHALL have port CODEC_write  out  SAMPLE_W  sample data to CODEC (both channels).
REQ-011 SHALL have port rom_addr  out  ADDR_W  clip ROM read address.
REQ-012 SHALL have port rom_data  in  SAMPLE_W  ROM data, valid exactly 1 cycle after rom_addr.
REQ-013 SHALL have port grant  out  4  one-hot requester currently playing; 0 when idle.
REQ-014 SHALL have port busy  out  1  clip in progress.
REQ-015 SHALL have port sampleDone  out  1  one-cycle pulse at clip end.

Function
REQ-016 SHALL latch each req pulse into pending[i]; repeated pulses while pending[i]=1 are absorbed.
REQ-017 SHALL, in IDLE with any pending bit set, grant round-robin starting at the index after the last grant (index 0 after reset), and clear that pending bit on the grant cycle.
REQ-018 SHALL select clip id at grant: req0 -> digit clip redCount, req1 -> digit clip greenCount, req2 -> RED clip, req3 -> GREEN clip; tally is frozen for the clip.
REQ-019 SHALL use FSM states IDLE, FETCH, WAIT_ROM, PUSH, DONE.
REQ-020 SHALL transition IDLE->FETCH on grant; FETCH drives rom_addr=start+idx -> WAIT_ROM; WAIT_ROM registers rom_data into CODEC_write -> PUSH.
REQ-021 SHALL in PUSH drive write=write_ready; a sample is consumed on the cycle write_ready=1; CODEC_write stays stable until consumed.
REQ-022 SHALL after consumption go to FETCH with idx+1, or to DONE if idx = length-1.
REQ-023 SHALL in DONE pulse sampleDone for one cycle, clear grant, return to IDLE; the next grant is possible the following cycle.
REQ-024 SHALL in IDLE, FETCH, WAIT_ROM and DONE drive CODEC_write=0 and write=write_ready, so the CODEC streams silence whenever no clip sample is pending.
REQ-025 SHALL assert busy in every state except IDLE; grant is held constant from FETCH through DONE.
REQ-026 SHALL accept req for the currently granted index: sets pending, clip replays after the current one (subject to round-robin).
REQ-027 SHALL handle simultaneous req pulses in one cycle: all latched, served in round-robin order.
REQ-028 SHALL keep idx ADDR_W wide; start+idx never exceeds the clip's range (no wrap).

Reset
REQ-029 SHALL on reset=1 at any time, including mid-clip, go to IDLE, clear pending, idx, grant, busy, sampleDone, CODEC_write, rom_addr, and set the RR pointer so index 0 wins first.
REQ-030 SHALL drive write=0 while reset=1.

Structure
REQ-031 SHALL place in package clip_pkg: the state enum, clip id type (0..15 digits, 16 RED, 17 GREEN), and CLIP_START/CLIP_LEN constant tables; every CLIP_LEN >= 1.
REQ-032 SHALL implement the round-robin arbiter as sub-module rr_arbiter4 (pending, pointer -> one-hot grant).

Verification
REQ-033 SHALL verify single req: ROM model returns data=addr, write_ready=1, req[2] pulse -> CODEC_write walks CLIP_START[16]..+CLIP_LEN[16]-1, then one sampleDone.
REQ-034 SHALL verify backpressure: write_ready toggled 1-of-4 cycles -> no sample lost or duplicated, write never high with write_ready=0.
REQ-035 SHALL verify arbitration: req=4'b1111 in one cycle after reset -> grant order 0001, 0010, 0100, 1000, four sampleDone pulses.
REQ-036 SHALL verify tally freeze: redCount=7, req[0], then redCount=3 mid-clip -> digit-7 addresses throughout.
REQ-037 SHALL verify reset mid-clip at idx 2: next cycle IDLE, grant=0, pending=0, no sampleDone; a fresh req[3] plays from idx 0.
REQ-038 SHALL verify re-request: req[1] twice while granted to 1 -> clip plays exactly twice total.
